// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Puts the word requests of the data cache and the instruction cache onto the
// single RAM port. Data-side requests win. A bounded streak counter forces one
// instruction grant after MAX_DSTREAK back-to-back data grants made while an
// instruction fetch was waiting, so fetch cannot starve during long fills.
//
// Every grant passes back through IDLE, which re-arbitrates, so each word
// takes at least two cycles.
//
// Parameters:
//   MAX_DSTREAK   data grants allowed while iREN waits (1..15)
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-high reset
//   dREN, dWEN         dcache read / write request
//   daddr, dstore      dcache word address / write data
//   dload, dwait       dcache load data / wait (0 only in the completing cycle)
//   iREN, iaddr        icache read request / word address
//   iload, iwait       icache load data / wait (0 only in the completing cycle)
//   ramREN, ramWEN     RAM read / write strobes
//   ramaddr, ramstore  RAM address / write data
//   ramload, ramstate  RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//
// Optional build macro MEM_ARBITER_PERF_EN adds three 32-bit counters:
//   dgrant_cnt  completed data transactions
//   igrant_cnt  completed instruction transactions
//   err_cnt     cycles spent granted while ramstate reports ERROR
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARBITER_PERF_EN
    ,
    output logic [31:0] dgrant_cnt,
    output logic [31:0] igrant_cnt,
    output logic [31:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [3:0] STREAK_LIM = 4'(MAX_DSTREAK);

    state_t     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       dreq;
    logic       d_done;
    logic       i_done;

    assign dreq = dREN | dWEN;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        dwait    = 1'b1;
        iwait    = 1'b1;
        dload    = 32'd0;
        iload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        d_done   = 1'b0;
        i_done   = 1'b0;

        case (state_q)
            IDLE: begin
                // Data wins unless an instruction fetch has waited out the
                // full streak of data grants.
                if (dreq && !(iREN && (streak_q >= STREAK_LIM))) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end

            DGRANT: begin
                if (!dreq) begin
                    // Requester withdrew: drop strobes now, keep the streak.
                    state_d = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == RAM_ACCESS) begin
                        dwait   = 1'b0;
                        dload   = ramload;
                        d_done  = 1'b1;
                        state_d = IDLE;
                        // Only grants made while a fetch waits count toward
                        // the streak.
                        if (iREN) begin
                            streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
                        end else begin
                            streak_d = 4'd0;
                        end
                    end
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RAM_ACCESS) begin
                        iwait    = 1'b0;
                        iload    = ramload;
                        i_done   = 1'b1;
                        streak_d = 4'd0;
                        state_d  = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] dgrant_cnt_q;
    logic [31:0] igrant_cnt_q;
    logic [31:0] err_cnt_q;
    logic        granted;

    assign granted = (state_q == DGRANT) || (state_q == IGRANT);

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            dgrant_cnt_q <= 32'd0;
            igrant_cnt_q <= 32'd0;
            err_cnt_q    <= 32'd0;
        end else begin
            if (d_done) begin
                dgrant_cnt_q <= dgrant_cnt_q + 32'd1;
            end
            if (i_done) begin
                igrant_cnt_q <= igrant_cnt_q + 32'd1;
            end
            if (granted && (ramstate == RAM_ERROR)) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign dgrant_cnt = dgrant_cnt_q;
    assign igrant_cnt = igrant_cnt_q;
    assign err_cnt    = err_cnt_q;
`else
    // Completion flags only feed the optional counters.
    logic unused_done;
    assign unused_done = d_done ^ i_done;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the data cache and the instruction cache.
- Arbitrates their word requests onto the single RAM port and returns load data and per-requester wait signals.
- Data-side requests have priority.
- A bounded-streak rule keeps instruction fetch from starving during long dcache fills, write-backs or halt flushes.

Parameters:
- MAX_DSTREAK, 4: maximum consecutive data grants while iREN is pending before one instruction grant is forced; legal range 1-15.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-high (1 = reset asserted)
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dload  out  32  data returned to dcache
- dwait  out  1  dcache wait; 0 only in the completing cycle
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iload  out  32  instruction returned to icache
- iwait  out  1  icache wait; 0 only in the completing cycle
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset state, held while nRST=1:
  - FSM in IDLE; streak counter = 0.
  - dwait = iwait = 1.
  - ramREN = ramWEN = 0; ramaddr = ramstore = 0.
  - dload = iload = 0.
- FSM states: IDLE, DGRANT, IGRANT. State and streak are registered.
- All outputs are combinational from state plus the current inputs of the granted requester.
- IDLE:
  - No RAM strobes; dwait = iwait = 1.
  - dreq = dREN|dWEN.
  - If dreq and not (iREN and streak >= MAX_DSTREAK): go to DGRANT.
  - Else if iREN: go to IGRANT.
  - Else stay in IDLE.
- DGRANT:
  - ramaddr = daddr; ramstore = dstore.
  - ramWEN = dWEN. ramREN = dREN & ~dWEN, so write wins when both are high.
  - When ramstate == ACCESS:
    - dwait = 0; dload = ramload.
    - Streak increments, saturating at 15, if iREN is high; otherwise it clears to 0.
    - Next state IDLE.
  - BUSY, FREE or ERROR: dwait = 1, strobes held, stay in DGRANT. ERROR is retried indefinitely.
  - If dreq drops before ACCESS: abort that cycle. Strobes go to 0 combinationally, dwait = 1, next state IDLE, streak unchanged.
- IGRANT:
  - ramREN = 1; ramaddr = iaddr; ramWEN = 0.
  - On ACCESS: iwait = 0, iload = ramload, streak cleared to 0, next state IDLE.
  - If iREN drops before ACCESS: abort as above.
- The non-granted side always sees wait = 1 and load = 0.
- Latency:
  - A request seen in IDLE in cycle N drives the RAM from cycle N+1.
  - With a zero-wait RAM (ACCESS in the first granted cycle), completion is at N+1.
  - Each word costs at least 2 cycles (the IDLE turnaround re-arbitrates).
- A dcache two-word block fill or write-back is therefore two separate grants. An icache request may only interleave between them when the streak limit forces it.
- daddr, iaddr and ramaddr pass through unmodified (no alignment check).
- Reset asserted mid-grant: strobes drop asynchronously and the FSM returns to IDLE. Any transaction in flight is lost, and the requester reissues it.

Optional Feature:
- Macro MEM_ARBITER_PERF_EN.
- When defined, three 32-bit output ports are added:
  - dgrant_cnt: completed data transactions.
  - igrant_cnt: completed instruction transactions.
  - err_cnt: cycles with ramstate == ERROR while granted.
- All three counters reset to 0, wrap modulo 2^32, and are readable at any time.
- When undefined, the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Lone read: iREN=1, iaddr=0x40, RAM zero-wait returning 0xDEADBEEF. Required: iwait=0 and iload=0xDEADBEEF in cycle 2; ramREN high only in cycle 2.
- Simultaneous requests: dREN=1 at daddr=0x3100 and iREN=1 in the same cycle. Required: data is granted first (dwait=0 with iwait=1), then the instruction grant follows two cycles later.
- Streak limit: MAX_DSTREAK=4, dWEN held continuously, iREN held. Required: exactly 4 data completions, then 1 instruction completion, then data grants resume with the streak reset to 0.
- Slow RAM: ramstate=BUSY for 3 cycles then ACCESS, with a data write of 0x12345678 to 0x80. Required: ramWEN, ramaddr and ramstore stable for all 4 cycles; dwait low only on the ACCESS cycle.
- Abort: dREN dropped in the second BUSY cycle. Required: ramREN=0 in that same cycle, FSM in IDLE the next cycle, no dwait=0 pulse.
- Reset during grant: nRST pulsed high while in IGRANT. Required: ramREN=0 and iwait=1 immediately; with MEM_ARBITER_PERF_EN, all counters read 0.
